// File: rtl/mem_retimer_pkg.sv
// Shared types and limits for the memory port retimer.
// Imported by the per-channel engine and the multi-channel top.
package mem_retimer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } ch_state_e;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    function automatic bit lat_ok(input int lat);
        return (lat >= LAT_MIN) && (lat <= LAT_MAX);
    endfunction

endpackage

// File: rtl/mem_retimer_ch.sv
// One retiming channel: request masking FSM, timeout counter,
// response delay line and sticky error flags.
module mem_retimer_ch
    import mem_retimer_pkg::*;
#(
    parameter int DW   = 128,
    parameter int LAT  = 1,
    parameter int TO_W = 10
) (
    input  logic          clk,
    input  logic          proc_reset,
    input  logic          c_read,
    input  logic          c_write,
    output logic [DW-1:0] c_rdata,
    output logic          c_ready,
    output logic          m_read,
    output logic          m_write,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    input  logic          err_clear,
    output logic          err_timeout,
    output logic          err_proto
);

    if (!lat_ok(LAT)) begin : g_bad_lat
        $error("mem_retimer_ch: LAT out of range 1..4");
    end

    ch_state_e       state;
    ch_state_e       state_nx;
    logic [TO_W-1:0] cnt;
    logic [TO_W-1:0] cnt_nx;
    logic [LAT-1:0]  rdy_pipe;
    logic [DW-1:0]   data_pipe [LAT];
    logic            launch;
    logic            to_set;
    logic            pe_set;
    logic            req;
    logic            clash;

    assign req     = c_read | c_write;
    assign clash   = c_read & c_write;
    assign c_ready = rdy_pipe[LAT-1];
    assign c_rdata = data_pipe[LAT-1];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        launch   = 1'b0;
        to_set   = 1'b0;
        pe_set   = 1'b0;
        m_read   = 1'b0;
        m_write  = 1'b0;
        unique case (state)
            IDLE: begin
                m_read  = c_read & ~c_write;
                m_write = c_write;
                pe_set  = m_ready | clash;
                if (req) state_nx = REQ;
            end
            REQ: begin
                m_read  = c_read & ~c_write;
                m_write = c_write;
                pe_set  = clash;
                if (m_ready) begin
                    launch   = 1'b1;
                    cnt_nx   = '0;
                    state_nx = DRAIN;
                end else if (!req) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    // Saturating: the flag keeps re-arming while stuck.
                    cnt_nx = (&cnt) ? cnt : cnt + 1'b1;
                    to_set = &cnt_nx;
                end
            end
            DRAIN: begin
                pe_set = m_ready;
                if (c_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (proc_reset) begin
            m_read  = 1'b0;
            m_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state       <= IDLE;
            cnt         <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
            rdy_pipe    <= '0;
            for (int i = 0; i < LAT; i++) data_pipe[i] <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            err_timeout <= to_set | (err_timeout & ~err_clear);
            err_proto   <= pe_set | (err_proto & ~err_clear);
            rdy_pipe[0]  <= launch;
            data_pipe[0] <= m_rdata;
            for (int i = 1; i < LAT; i++) begin
                rdy_pipe[i]  <= rdy_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

endmodule

// File: rtl/mem_port_retimer.sv
// Multi-channel retiming bridge between cache mem ports and slow memory.
// ch0 = D-cache, ch1 = I-cache; channels never interact.
module mem_port_retimer
    import mem_retimer_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int DW   = 128,
    parameter int AW   = 28,
    parameter int LAT  = 1,
    parameter int TO_W = 10
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic [NCH-1:0]    c_read,
    input  logic [NCH-1:0]    c_write,
    input  logic [NCH*AW-1:0] c_addr,
    input  logic [NCH*DW-1:0] c_wdata,
    output logic [NCH*DW-1:0] c_rdata,
    output logic [NCH-1:0]    c_ready,
    output logic [NCH-1:0]    m_read,
    output logic [NCH-1:0]    m_write,
    output logic [NCH*AW-1:0] m_addr,
    output logic [NCH*DW-1:0] m_wdata,
    input  logic [NCH*DW-1:0] m_rdata,
    input  logic [NCH-1:0]    m_ready,
    output logic [NCH-1:0]    err_timeout,
    output logic [NCH-1:0]    err_proto,
    input  logic              err_clear
);

    assign m_addr  = c_addr;
    assign m_wdata = c_wdata;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        mem_retimer_ch #(
            .DW  (DW),
            .LAT (LAT),
            .TO_W(TO_W)
        ) u_ch (
            .clk        (clk),
            .proc_reset (proc_reset),
            .c_read     (c_read[k]),
            .c_write    (c_write[k]),
            .c_rdata    (c_rdata[k*DW +: DW]),
            .c_ready    (c_ready[k]),
            .m_read     (m_read[k]),
            .m_write    (m_write[k]),
            .m_rdata    (m_rdata[k*DW +: DW]),
            .m_ready    (m_ready[k]),
            .err_clear  (err_clear),
            .err_timeout(err_timeout[k]),
            .err_proto  (err_proto[k])
        );
    end

endmodule
